// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake and bus signal around mem_arbiter.
//   ifu_*  : instruction fetch request/response (read-only requester)
//   lsu_*  : load/store request/response (read/write requester)
//   mem_*  : single shared memory port
//   busy   : arbiter has a transaction in flight
// Modports:
//   slave  : the arbiter's view (consumes requests, drives memory port)
//   master : the environment's view (requesters plus memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_resp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch unit (IFU, read-only)
// and the load/store unit (LSU). One transaction at a time:
//   IDLE -> REQ (drive memory request) -> WAIT (await response / timeout)
//        -> RESP (one-cycle response pulse to the granted requester) -> IDLE
// Ties in IDLE are broken round-robin using the last granted requester.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave carrying all requester and memory signals
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int          MASK_W    = DATA_W / 8;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic        GRANT_IFU = 1'b0;
  localparam logic        GRANT_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_r;
  logic                last_grant_r;
  logic                grant_id_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [MASK_W-1:0]   wmask_r;
  logic                mem_req_valid_r;
  logic [15:0]         cnt_r;
  logic                ifu_resp_valid_r;
  logic [DATA_W-1:0]   ifu_rdata_r;
  logic                ifu_resp_err_r;
  logic                lsu_resp_valid_r;
  logic [DATA_W-1:0]   lsu_rdata_r;
  logic                lsu_resp_err_r;

  logic                ifu_ready_s;
  logic                lsu_ready_s;
  logic                resp_fire_s;
  logic [DATA_W-1:0]   resp_data_s;
  logic                resp_err_s;

  // Grant selection: exactly one ready in IDLE, round-robin on a tie.
  always_comb begin
    ifu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    if (state_r == IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        if (last_grant_r == GRANT_LSU) begin
          ifu_ready_s = 1'b1;
        end else begin
          lsu_ready_s = 1'b1;
        end
      end else if (bus.ifu_req_valid) begin
        ifu_ready_s = 1'b1;
      end else if (bus.lsu_req_valid) begin
        lsu_ready_s = 1'b1;
      end else begin
        ifu_ready_s = 1'b0;
      end
    end else begin
      ifu_ready_s = 1'b0;
    end
  end

  // WAIT exit decision. WAIT lasts at most TIMEOUT+1 cycles (counter values
  // 0..TIMEOUT); a memory response in the final cycle still beats the timeout.
  always_comb begin
    resp_fire_s = 1'b0;
    resp_data_s = {DATA_W{1'b0}};
    resp_err_s  = 1'b0;
    if (state_r == WAIT) begin
      if (bus.mem_resp_valid) begin
        resp_fire_s = 1'b1;
        resp_data_s = wen_r ? {DATA_W{1'b0}} : bus.mem_rdata;
      end else if (cnt_r == TIMEOUT_C) begin
        resp_fire_s = 1'b1;
        resp_err_s  = 1'b1;
      end else begin
        resp_fire_s = 1'b0;
      end
    end else begin
      resp_fire_s = 1'b0;
    end
  end

  // Transaction FSM with registered memory request and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      last_grant_r     <= GRANT_LSU;
      grant_id_r       <= GRANT_IFU;
      addr_r           <= {ADDR_W{1'b0}};
      wen_r            <= 1'b0;
      wdata_r          <= {DATA_W{1'b0}};
      wmask_r          <= {MASK_W{1'b0}};
      mem_req_valid_r  <= 1'b0;
      cnt_r            <= 16'd0;
      ifu_resp_valid_r <= 1'b0;
      ifu_rdata_r      <= {DATA_W{1'b0}};
      ifu_resp_err_r   <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      lsu_rdata_r      <= {DATA_W{1'b0}};
      lsu_resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ifu_ready_s && bus.ifu_req_valid) begin
            addr_r          <= bus.ifu_addr;
            wen_r           <= 1'b0;
            wdata_r         <= {DATA_W{1'b0}};
            wmask_r         <= {MASK_W{1'b0}};
            last_grant_r    <= GRANT_IFU;
            grant_id_r      <= GRANT_IFU;
            mem_req_valid_r <= 1'b1;
            state_r         <= REQ;
          end else if (lsu_ready_s && bus.lsu_req_valid) begin
            addr_r          <= bus.lsu_addr;
            wen_r           <= bus.lsu_wen;
            wdata_r         <= bus.lsu_wdata;
            wmask_r         <= bus.lsu_wmask;
            last_grant_r    <= GRANT_LSU;
            grant_id_r      <= GRANT_LSU;
            mem_req_valid_r <= 1'b1;
            state_r         <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            cnt_r           <= 16'd0;
            state_r         <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire_s) begin
            if (grant_id_r == GRANT_LSU) begin
              lsu_resp_valid_r <= 1'b1;
              lsu_rdata_r      <= resp_data_s;
              lsu_resp_err_r   <= resp_err_s;
            end else begin
              ifu_resp_valid_r <= 1'b1;
              ifu_rdata_r      <= resp_data_s;
              ifu_resp_err_r   <= resp_err_s;
            end
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RESP: begin
          ifu_resp_valid_r <= 1'b0;
          ifu_rdata_r      <= {DATA_W{1'b0}};
          ifu_resp_err_r   <= 1'b0;
          lsu_resp_valid_r <= 1'b0;
          lsu_rdata_r      <= {DATA_W{1'b0}};
          lsu_resp_err_r   <= 1'b0;
          state_r          <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_ready_s;
  assign bus.ifu_resp_valid = ifu_resp_valid_r;
  assign bus.ifu_rdata      = ifu_rdata_r;
  assign bus.ifu_resp_err   = ifu_resp_err_r;
  assign bus.lsu_req_ready  = lsu_ready_s;
  assign bus.lsu_resp_valid = lsu_resp_valid_r;
  assign bus.lsu_rdata      = lsu_rdata_r;
  assign bus.lsu_resp_err   = lsu_resp_err_r;
  assign bus.mem_req_valid  = mem_req_valid_r;
  assign bus.mem_addr       = addr_r;
  assign bus.mem_wen        = wen_r;
  assign bus.mem_wdata      = wdata_r;
  assign bus.mem_wmask      = wmask_r;
  assign bus.busy           = (state_r != IDLE);
endmodule
